// File: rtl/exec_unit_mc.sv
// exec_unit_mc: multi-cycle execution unit for the J17 core.
//   Holds the register file, the ALU and the program counter. It accepts one
//   decoded instruction per in_valid/in_ready handshake, executes it, writes
//   back to the register file and advances PC.
//
// Optional feature macro: EXEC_MULDIV_EN
//   defined   : alucodes 3/4/5 (mul/div/mod) run on an iterative engine
//               (WIDTH shift-add or restoring-divide steps, then retire).
//   undefined : no iterative engine; codes 3/4/5 return all-ones in one cycle.
//
// Ports:
//   clock, reset_n     rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready  instruction handshake (in_ready high only when idle)
//   alucode            ALU operation
//   rd, rs1, rs2       destination / operand register indices
//   imm, imControl     immediate; replaces regs[rs2] as operand 2 when imControl=1
//   regenable          enable register write at retire
//   writecode          write source: 0 ALU, 1 imm, 2 mem_rdata, 3 none
//   pcControl          0 PC+1, 1 branch-if-equal, 2 jump to imm, 3 hold
//   mem_rdata          load data, captured at accept
//   result             last retired ALU result
//   done               one-cycle pulse at retire
//   PC                 program counter
//   busy               inverse of in_ready
module exec_unit_mc #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int PC_W  = 32,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alucode,
  input  logic [RW-1:0]    rd,
  input  logic [RW-1:0]    rs1,
  input  logic [RW-1:0]    rs2,
  input  logic [WIDTH-1:0] imm,
  input  logic             imControl,
  input  logic             regenable,
  input  logic [1:0]       writecode,
  input  logic [1:0]       pcControl,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic [PC_W-1:0]  PC,
  output logic             busy
);

`ifdef EXEC_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER} state_t;
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0] cnt;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXEC} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] regs [NREGS];

  logic             accept;
  logic [WIDTH-1:0] rs1_data, num2_sel;

  logic [WIDTH-1:0] num1_p0, num2_p0, imm_p0, mdata_p0;
  logic [3:0]       op_p0;
  logic [RW-1:0]    rd_p0;
  logic             regen_p0;
  logic [1:0]       wcode_p0, pcc_p0;

  logic [WIDTH-1:0] alu_res, wb_data;
  logic             wb_en;
  logic [PC_W-1:0]  pc_next;

  function automatic logic [WIDTH-1:0] alu_f(input logic [3:0]       op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    case (op)
      4'd0:    return a;
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd6:    return a | b;
      4'd7:    return a & b;
      4'd8:    return a ^ b;
      4'd9:    return ~a;
      4'd10:   return a >> 1;
      4'd11:   return a << 1;
      default: return '1;
    endcase
  endfunction

  assign in_ready = (state == S_IDLE);
  assign busy     = ~in_ready;
  assign accept   = in_valid && (state == S_IDLE);

  // r0 is never written, so it always reads back as zero.
  assign rs1_data = regs[rs1];
  assign num2_sel = imControl ? imm : regs[rs2];

  // Accept stage: capture operands and control so later writes cannot disturb
  // an in-flight instruction.
  always_ff @(posedge clock) begin
    if (accept) begin
      num1_p0  <= rs1_data;
      num2_p0  <= num2_sel;
      imm_p0   <= imm;
      mdata_p0 <= mem_rdata;
      op_p0    <= alucode;
      rd_p0    <= rd;
      regen_p0 <= regenable;
      wcode_p0 <= writecode;
      pcc_p0   <= pcControl;
    end
  end

`ifdef EXEC_MULDIV_EN
  // Iterative engine. eng_acc is the product accumulator (mul) or the partial
  // remainder (div/mod); eng_x is the shifting multiplicand, or the dividend
  // that turns into the quotient as its bits are consumed; eng_y is the
  // multiplier or the divisor. A zero divisor always "fits", which naturally
  // yields quotient all-ones and remainder num1.
  logic [WIDTH-1:0] eng_acc, eng_x, eng_y;
  logic [WIDTH:0]   rem_sh, rem_diff;

  assign rem_sh   = {eng_acc, eng_x[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, eng_y};

  always_ff @(posedge clock) begin
    if (accept) begin
      eng_acc <= '0;
      eng_x   <= rs1_data;
      eng_y   <= num2_sel;
    end else if (state == S_ITER) begin
      if (op_p0 == 4'd3) begin
        if (eng_y[0]) eng_acc <= eng_acc + eng_x;
        eng_x <= eng_x << 1;
        eng_y <= eng_y >> 1;
      end else if (!rem_diff[WIDTH]) begin
        eng_acc <= rem_diff[WIDTH-1:0];
        eng_x   <= {eng_x[WIDTH-2:0], 1'b1};
      end else begin
        eng_acc <= rem_sh[WIDTH-1:0];
        eng_x   <= {eng_x[WIDTH-2:0], 1'b0};
      end
    end
  end
`endif

  always_comb begin
    alu_res = alu_f(op_p0, num1_p0, num2_p0);
`ifdef EXEC_MULDIV_EN
    case (op_p0)
      4'd3, 4'd5: alu_res = eng_acc;
      4'd4:       alu_res = eng_x;
      default:    ;
    endcase
`endif
    case (wcode_p0)
      2'd0:    wb_data = alu_res;
      2'd1:    wb_data = imm_p0;
      default: wb_data = mdata_p0;
    endcase
    wb_en = regen_p0 && (wcode_p0 != 2'd3) && (rd_p0 != '0);
    case (pcc_p0)
      2'd0:    pc_next = PC + PC_W'(1);
      2'd1:    pc_next = (num1_p0 == num2_p0) ? PC + imm_p0[PC_W-1:0] : PC + PC_W'(1);
      2'd2:    pc_next = imm_p0[PC_W-1:0];
      default: pc_next = PC;
    endcase
  end

  // Control / retire stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      PC     <= '0;
      result <= '0;
      done   <= 1'b0;
`ifdef EXEC_MULDIV_EN
      cnt    <= '0;
`endif
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
`ifdef EXEC_MULDIV_EN
            if (alucode == 4'd3 || alucode == 4'd4 || alucode == 4'd5) begin
              state <= S_ITER;
              cnt   <= CW'(WIDTH - 1);
            end else begin
              state <= S_EXEC;
            end
`else
            state <= S_EXEC;
`endif
          end
        end
`ifdef EXEC_MULDIV_EN
        // The step taken with cnt==0 is the last of WIDTH; retire next cycle.
        S_ITER: begin
          if (cnt == '0) state <= S_EXEC;
          else           cnt   <= cnt - 1'b1;
        end
`endif
        default: begin
          done   <= 1'b1;
          result <= alu_res;
          PC     <= pc_next;
          if (wb_en) regs[rd_p0] <= wb_data;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit_mc.sv
module tb_exec_unit_mc;
  localparam int W = 32;
`ifdef EXEC_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset_n;
  logic         in_valid, in_ready;
  logic [3:0]   alucode;
  logic [4:0]   rd, rs1, rs2;
  logic [W-1:0] imm, mem_rdata, result;
  logic         imControl, regenable, done, busy;
  logic [1:0]   writecode, pcControl;
  logic [31:0]  PC;

  int total = 0;
  int bad   = 0;

  // Behavioural reference state
  logic [W-1:0] mregs [32];
  logic [31:0]  mpc;
  logic [W-1:0] mres;

  exec_unit_mc #(.WIDTH(W), .NREGS(32), .PC_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .alucode(alucode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imControl(imControl), .regenable(regenable), .writecode(writecode),
    .pcControl(pcControl), .mem_rdata(mem_rdata), .result(result), .done(done),
    .PC(PC), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      4'd0:  return a;
      4'd1:  return a + b;
      4'd2:  return a - b;
      4'd3:  return MULDIV ? p[W-1:0] : '1;
      4'd4:  return !MULDIV ? '1 : (b == 0) ? '1 : a / b;
      4'd5:  return !MULDIV ? '1 : (b == 0) ? a : a % b;
      4'd6:  return a | b;
      4'd7:  return a & b;
      4'd8:  return a ^ b;
      4'd9:  return ~a;
      4'd10: return a >> 1;
      4'd11: return a << 1;
      default: return '1;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
    return (MULDIV && (op == 4'd3 || op == 4'd4 || op == 4'd5)) ? W + 1 : 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mpc  = '0;
    mres = '0;
  endtask

  task automatic model_exec(input logic [3:0] op, input logic [4:0] d, input logic [4:0] s1,
                            input logic [4:0] s2, input logic [W-1:0] im, input logic imc,
                            input logic regen, input logic [1:0] wc, input logic [1:0] pcc,
                            input logic [W-1:0] md, output int elat);
    logic [W-1:0] a, b, v;
    a = mregs[s1];
    b = imc ? im : mregs[s2];
    v = ref_alu(op, a, b);
    mres = v;
    if (regen && wc != 2'd3 && d != 5'd0)
      mregs[d] = (wc == 2'd0) ? v : (wc == 2'd1) ? im : md;
    case (pcc)
      2'd0: mpc = mpc + 1;
      2'd1: mpc = (a == b) ? mpc + im : mpc + 1;
      2'd2: mpc = im;
      default: ;
    endcase
    elat = ref_lat(op);
  endtask

  // Drives one instruction and returns the number of clocks from accept to done
  // (-1 if in_ready or done never shows up in time).
  task automatic issue(input logic [3:0] op, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [W-1:0] im, input logic imc,
                       input logic regen, input logic [1:0] wc, input logic [1:0] pcc,
                       input logic [W-1:0] md, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clock); #1; n++; end
    alucode = op; rd = d; rs1 = s1; rs2 = s2; imm = im; imControl = imc;
    regenable = regen; writecode = wc; pcControl = pcc; mem_rdata = md;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clock); #1;
      if (done) begin lat = c; break; end
    end
  endtask

  task automatic read_reg(input logic [4:0] r, output logic [W-1:0] val);
    int lat;
    issue(4'd0, 5'd0, r, 5'd0, '0, 1'b0, 1'b0, 2'd3, 2'd3, '0, lat);
    val = result;
  endtask

  task automatic test_reset();
    logic [W-1:0] v;
    reset_n = 1'b0; in_valid = 1'b0; alucode = '0; rd = '0; rs1 = '0; rs2 = '0;
    imm = '0; imControl = 1'b0; regenable = 1'b0; writecode = '0; pcControl = '0;
    mem_rdata = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (PC !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h want=0", PC); end
    total++; if (result !== '0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    read_reg(5'd5, v);
    total++; if (v !== '0) begin bad++; $display("FAIL reset_r5 got=%h want=0", v); end
  endtask

  task automatic test_addi();
    int lat, elat; logic [W-1:0] v;
    issue(4'd1, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 1'b1, 2'd0, 2'd0, '0, lat);
    model_exec(4'd1, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 1'b1, 2'd0, 2'd0, '0, elat);
    total++; if (lat != elat) begin bad++; $display("FAIL addi_latency got=%0d want=%0d", lat, elat); end
    total++; if (result !== mres) begin bad++; $display("FAIL addi_result got=%h want=%h", result, mres); end
    total++; if (PC !== mpc) begin bad++; $display("FAIL addi_pc got=%h want=%h", PC, mpc); end
    @(posedge clock); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL addi_done_pulse got=%b want=0", done); end
    read_reg(5'd1, v);
    total++; if (v !== mregs[1]) begin bad++; $display("FAIL addi_r1 got=%h want=%h", v, mregs[1]); end
  endtask

  task automatic test_branch();
    int lat, elat;
    issue(4'd1, 5'd2, 5'd0, 5'd0, 32'd5, 1'b1, 1'b1, 2'd0, 2'd0, '0, lat);
    model_exec(4'd1, 5'd2, 5'd0, 5'd0, 32'd5, 1'b1, 1'b1, 2'd0, 2'd0, '0, elat);
    issue(4'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 1'b0, 2'd3, 2'd1, '0, lat);
    model_exec(4'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 1'b0, 2'd3, 2'd1, '0, elat);
    total++; if (PC !== mpc) begin bad++; $display("FAIL branch_taken_pc got=%h want=%h", PC, mpc); end
    issue(4'd1, 5'd2, 5'd0, 5'd0, 32'd6, 1'b1, 1'b1, 2'd0, 2'd0, '0, lat);
    model_exec(4'd1, 5'd2, 5'd0, 5'd0, 32'd6, 1'b1, 1'b1, 2'd0, 2'd0, '0, elat);
    issue(4'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 1'b0, 2'd3, 2'd1, '0, lat);
    model_exec(4'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 1'b0, 2'd3, 2'd1, '0, elat);
    total++; if (PC !== mpc) begin bad++; $display("FAIL branch_not_taken_pc got=%h want=%h", PC, mpc); end
    issue(4'd0, 5'd0, 5'd0, 5'd0, 32'h40, 1'b1, 1'b0, 2'd3, 2'd2, '0, lat);
    model_exec(4'd0, 5'd0, 5'd0, 5'd0, 32'h40, 1'b1, 1'b0, 2'd3, 2'd2, '0, elat);
    total++; if (PC !== mpc) begin bad++; $display("FAIL jump_pc got=%h want=%h", PC, mpc); end
  endtask

  task automatic test_sub_r0();
    int lat, elat; logic [W-1:0] v;
    issue(4'd2, 5'd0, 5'd0, 5'd0, 32'd1, 1'b1, 1'b1, 2'd0, 2'd0, '0, lat);
    model_exec(4'd2, 5'd0, 5'd0, 5'd0, 32'd1, 1'b1, 1'b1, 2'd0, 2'd0, '0, elat);
    total++; if (result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sub_wrap got=%h want=ffffffff", result); end
    read_reg(5'd0, v);
    total++; if (v !== '0) begin bad++; $display("FAIL r0_zero got=%h want=0", v); end
  endtask

  task automatic test_muldiv();
    int lat, elat; logic [W-1:0] v;
    logic [3:0] ops [5]; logic [4:0] src [5]; logic [W-1:0] ims [5];
    ops = '{4'd3, 4'd4, 4'd5, 4'd4, 4'd5};
    src = '{5'd3, 5'd4, 5'd4, 5'd9, 5'd9};
    ims = '{32'd6, 32'd7, 32'd7, 32'd0, 32'd0};
    issue(4'd1, 5'd3, 5'd0, 5'd0, 32'd7, 1'b1, 1'b1, 2'd0, 2'd0, '0, lat);
    model_exec(4'd1, 5'd3, 5'd0, 5'd0, 32'd7, 1'b1, 1'b1, 2'd0, 2'd0, '0, elat);
    issue(4'd1, 5'd4, 5'd0, 5'd0, 32'd100, 1'b1, 1'b1, 2'd1, 2'd0, '0, lat);
    model_exec(4'd1, 5'd4, 5'd0, 5'd0, 32'd100, 1'b1, 1'b1, 2'd1, 2'd0, '0, elat);
    issue(4'd1, 5'd9, 5'd0, 5'd0, 32'd9, 1'b1, 1'b1, 2'd0, 2'd0, '0, lat);
    model_exec(4'd1, 5'd9, 5'd0, 5'd0, 32'd9, 1'b1, 1'b1, 2'd0, 2'd0, '0, elat);
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], 5'd10 + 5'(i), src[i], 5'd0, ims[i], 1'b1, 1'b1, 2'd0, 2'd0, '0, lat);
      model_exec(ops[i], 5'd10 + 5'(i), src[i], 5'd0, ims[i], 1'b1, 1'b1, 2'd0, 2'd0, '0, elat);
      total++; if (lat != elat) begin bad++; $display("FAIL muldiv_latency[%0d] got=%0d want=%0d", i, lat, elat); end
      total++; if (result !== mres) begin bad++; $display("FAIL muldiv_result[%0d] got=%h want=%h", i, result, mres); end
    end
    read_reg(5'd10, v);
    total++; if (v !== mregs[10]) begin bad++; $display("FAIL mul_writeback got=%h want=%h", v, mregs[10]); end
  endtask

  task automatic test_back_to_back();
    int lat, elat, nd, cyc, rdy_bad; logic [W-1:0] v;
    while (!in_ready) begin @(posedge clock); #1; end
    alucode = 4'd3; rd = 5'd3; rs1 = 5'd3; rs2 = 5'd0; imm = 32'd6; imControl = 1'b1;
    regenable = 1'b1; writecode = 2'd0; pcControl = 2'd0; mem_rdata = '0;
    model_exec(4'd3, 5'd3, 5'd3, 5'd0, 32'd6, 1'b1, 1'b1, 2'd0, 2'd0, '0, elat);
    in_valid = 1'b1;
    @(posedge clock); #1;
    nd = 0; lat = -1; rdy_bad = 0;
    for (cyc = 1; cyc <= elat + 4; cyc++) begin
      @(posedge clock); #1;
      if (cyc == 2) begin alucode = 4'd1; rd = 5'd4; rs1 = 5'd5; imm = $urandom; end
      if (done) begin
        nd++;
        if (lat < 0) lat = cyc;
        in_valid = 1'b0;
      end else if (lat < 0 && in_ready) rdy_bad++;
    end
    in_valid = 1'b0;
    total++; if (nd != 1) begin bad++; $display("FAIL hold_valid_retires got=%0d want=1", nd); end
    total++; if (lat != elat) begin bad++; $display("FAIL hold_valid_latency got=%0d want=%0d", lat, elat); end
    total++; if (rdy_bad != 0) begin bad++; $display("FAIL hold_valid_ready_while_busy got=%0d want=0", rdy_bad); end
    total++; if (result !== mres) begin bad++; $display("FAIL hold_valid_result got=%h want=%h", result, mres); end
    read_reg(5'd3, v);
    total++; if (v !== mregs[3]) begin bad++; $display("FAIL hold_valid_r3 got=%h want=%h", v, mregs[3]); end
    read_reg(5'd4, v);
    total++; if (v !== mregs[4]) begin bad++; $display("FAIL hold_valid_r4 got=%h want=%h", v, mregs[4]); end
  endtask

  task automatic test_random();
    int lat, elat; logic [W-1:0] v;
    logic [3:0] op; logic [4:0] d, s1, s2; logic [W-1:0] im, md;
    logic imc, regen; logic [1:0] wc, pcc;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15)); d = 5'($urandom_range(0, 7));
      s1 = 5'($urandom_range(0, 7)); s2 = 5'($urandom_range(0, 7));
      im = $urandom; if ($urandom_range(0, 2) == 0) im = $urandom_range(0, 3);
      imc = 1'($urandom_range(0, 1)); regen = 1'($urandom_range(0, 1));
      wc = 2'($urandom_range(0, 3)); pcc = 2'($urandom_range(0, 3)); md = $urandom;
      if (pcc == 2'd1 && $urandom_range(0, 1) == 1) begin imc = 1'b0; s2 = s1; end
      issue(op, d, s1, s2, im, imc, regen, wc, pcc, md, lat);
      model_exec(op, d, s1, s2, im, imc, regen, wc, pcc, md, elat);
      total++; if (lat != elat) begin bad++; $display("FAIL rand_latency[%0d] op=%0d got=%0d want=%0d", i, op, lat, elat); end
      total++; if (result !== mres) begin bad++; $display("FAIL rand_result[%0d] op=%0d got=%h want=%h", i, op, result, mres); end
      total++; if (PC !== mpc) begin bad++; $display("FAIL rand_pc[%0d] got=%h want=%h", i, PC, mpc); end
      if (i % 15 == 14) begin
        for (int r = 0; r < 8; r++) begin
          read_reg(5'(r), v);
          total++; if (v !== mregs[r]) begin bad++; $display("FAIL rand_reg[%0d] r%0d got=%h want=%h", i, r, v, mregs[r]); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_iter();
    int nd, elat, exp_nd; logic [W-1:0] pre_res, exp_r, v;
    while (!in_ready) begin @(posedge clock); #1; end
    pre_res = result;
    alucode = 4'd3; rd = 5'd6; rs1 = 5'd1; rs2 = 5'd0; imm = 32'd9; imControl = 1'b1;
    regenable = 1'b1; writecode = 2'd0; pcControl = 2'd0; mem_rdata = '0;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    exp_nd = (ref_lat(4'd3) <= 10) ? 1 : 0;
    exp_r  = (exp_nd == 1) ? '1 : pre_res;
    nd = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock); #1;
      if (done) nd++;
    end
    total++; if (nd != exp_nd) begin bad++; $display("FAIL mid_iter_retires_before_reset got=%0d want=%0d", nd, exp_nd); end
    total++; if (result !== exp_r) begin bad++; $display("FAIL mid_iter_result_before_reset got=%h want=%h", result, exp_r); end
    reset_n = 1'b0;
    model_reset();
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_iter_reset_ready got=%b want=1", in_ready); end
    total++; if (PC !== 32'd0) begin bad++; $display("FAIL mid_iter_reset_pc got=%h want=0", PC); end
    @(negedge clock); @(negedge clock); reset_n = 1'b1;
    nd = 0;
    for (int c = 0; c < W + 5; c++) begin
      @(posedge clock); #1;
      if (done) nd++;
    end
    total++; if (nd != 0) begin bad++; $display("FAIL mid_iter_done_after_reset got=%0d want=0", nd); end
    read_reg(5'd6, v);
    elat = 0;
    total++; if (v !== mregs[6]) begin bad++; $display("FAIL mid_iter_r6 got=%h want=%h", v, mregs[6]); end
    total++; if (PC !== mpc) begin bad++; $display("FAIL mid_iter_pc_after got=%h want=%h", PC, mpc); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_sub_r0();
    test_muldiv();
    test_back_to_back();
    test_random();
    test_reset_mid_iter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
